count_pulses: RTL and testbench
===============================

Name: count_pulses

Overview:
- Counts rising edges on an asynchronous single-bit pulse input (detector/photon pulses) over a batch window.
- On each batch_done event, publishes the accumulated count on reg_count and restarts counting from zero.
- Sits between the raw front-end pulse inputs and the readout/coincidence logic, entirely in the clk domain.

Parameters:
- WIDTH, 8: width of the internal counter and of reg_count.
- SYNC_STAGES, 2: number of flip-flops in the raw_pulses synchronizer; minimum 2, values below 2 are treated as 2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- raw_pulses  input  1  asynchronous pulse input; each 0->1 transition is one event.
- batch_done  input  1  synchronous batch-end request, clk domain; acted on at its rising edge.
- reg_count  output  WIDTH  count of events in the last completed batch.
- reg_valid  output  1  one-cycle strobe: reg_count was updated in the previous clock edge.

Behaviour:
- Reset:
  - Asserting rst_n low clears immediately, regardless of clk: synchronizer chain, edge-detect register, batch_done history register, internal counter cnt, reg_count, and reg_valid.
  - Reset applied mid-batch discards the partial count.
  - Reset is released synchronously by the system.
- Synchronizer:
  - raw_pulses passes through a SYNC_STAGES-deep FF chain, then one more register (prev) for edge detection.
  - evt = last_sync_stage & ~prev.
  - With SYNC_STAGES=2: a high level first sampled at edge k gives evt high during cycle k+1, and cnt changes at edge k+2.
- Pulse width:
  - A pulse must be high for at least one full clk edge sample to be seen. Narrower pulses may be missed.
  - A level held high counts once. A new event needs a low sample between highs.
- Batch event:
  - bd_rise = batch_done & ~bd_prev, where bd_prev is batch_done registered.
  - A batch_done held high for many cycles is one event.
- Per clock edge, in priority order:
  1. bd_rise: reg_count <= cnt; cnt <= evt ? 1 : 0; reg_valid <= 1.
     - An event coincident with the batch boundary is credited to the new batch.
  2. Otherwise, evt: cnt <= cnt + 1, with the overflow rule below; reg_valid <= 0.
  3. Otherwise: cnt holds; reg_valid <= 0.
- reg_count holds its value between batch events. It changes only on bd_rise or reset.
- Overflow (default build): cnt wraps modulo 2^WIDTH, so 255 + 1 -> 0 for WIDTH=8.
- Back-to-back bd_rise, i.e. batch_done toggling 1-0-1: each rise publishes. A batch with no events publishes 0.
- No combinational path from any input to any output.

Optional Feature:
- Macro COUNT_PULSES_SAT_EN.
- Defined:
  - cnt saturates at 2^WIDTH-1 instead of wrapping.
  - An extra output, reg_ovf (1 bit, reset 0), is latched alongside reg_count on bd_rise. It is 1 if the published batch hit saturation with at least one event lost.
  - The saturation flag is cleared with cnt at the batch boundary, unless the boundary-coincident event alone causes it, which cannot occur for WIDTH>=1.
- Undefined: wrap-around counting as above, and the reg_ovf port does not exist.

Test Plan:
- Reset: drive rst_n low mid-count with clk stopped -> reg_count=0, reg_valid=0 immediately. Release, then one bd_rise with no pulses -> reg_count=0, reg_valid pulses one cycle.
- Periodic: 1-cycle raw_pulses high every 5 clks, batch_done 1-cycle every 50 clks -> every batch after the first publishes reg_count=10, with reg_valid one cycle after each bd_rise.
- Coincidence: a pulse edge whose evt lands in the same cycle as bd_rise -> the published count excludes it; the next batch starts at cnt=1 and publishes 1 if no further pulses arrive.
- Level/edge: raw_pulses held high 20 cycles, then low, then high 3 cycles, then batch_done held high 10 cycles -> reg_count=2, single reg_valid strobe.
- Wrap: 257 separated pulses then bd_rise -> reg_count=1 (default build). With COUNT_PULSES_SAT_EN: reg_count=255, reg_ovf=1.
- Latency: single pulse sampled at edge k, SYNC_STAGES=2, bd_rise at edge k+1 -> reg_count=0; bd_rise at edge k+3 -> reg_count=1.

Source files
------------

// File: rtl/count_pulses.sv
// Batch pulse counter: synchronizes raw_pulses, counts rising edges, publishes on batch_done.
// Define COUNT_PULSES_SAT_EN for a saturating counter with the reg_ovf flag.
module count_pulses #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             raw_pulses,
    input  logic             batch_done,
    output logic [WIDTH-1:0] reg_count,
`ifdef COUNT_PULSES_SAT_EN
    output logic             reg_ovf,
`endif
    output logic             reg_valid
);

    localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [NS-1:0]    sync_q;
    logic             prev_q;
    logic             bd_prev_q;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_inc;
    logic             evt;
    logic             bd_rise;

    assign evt     = sync_q[NS-1] & ~prev_q;
    assign bd_rise = batch_done & ~bd_prev_q;

`ifdef COUNT_PULSES_SAT_EN
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic sat_q;
    logic lost;

    // An event arriving at full scale is dropped and remembered.
    assign lost    = evt && (cnt == CNT_MAX);
    assign cnt_inc = lost ? cnt : cnt + ONE;
`else
    assign cnt_inc = cnt + ONE;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[NS-2:0], raw_pulses};
            prev_q <= sync_q[NS-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bd_prev_q <= 1'b0;
            cnt       <= '0;
            reg_count <= '0;
            reg_valid <= 1'b0;
`ifdef COUNT_PULSES_SAT_EN
            sat_q     <= 1'b0;
            reg_ovf   <= 1'b0;
`endif
        end else begin
            bd_prev_q <= batch_done;
            if (bd_rise) begin
                // A coincident event opens the new batch.
                reg_count <= cnt;
                cnt       <= WIDTH'(evt);
                reg_valid <= 1'b1;
`ifdef COUNT_PULSES_SAT_EN
                reg_ovf   <= sat_q;
                sat_q     <= 1'b0;
`endif
            end else begin
                reg_valid <= 1'b0;
                if (evt) begin
                    cnt <= cnt_inc;
`ifdef COUNT_PULSES_SAT_EN
                    sat_q <= sat_q | lost;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_count_pulses.sv
// Randomized and directed bench for count_pulses.
// Reference model credits each pulse two edges after first sample and tallies per batch.
module tb_count_pulses;

    localparam int MAXV = 255;

    logic       clk = 1'b0;
    logic       clk_en = 1'b1;
    logic       rst_n;
    logic       raw_pulses;
    logic       batch_done;
    logic [7:0] reg_count;
    logic       reg_valid;
`ifdef COUNT_PULSES_SAT_EN
    logic       reg_ovf;
    logic       exp_ovf;
`endif

    int   n_edge;
    int   credit_q[$];
    logic r_prev;
    logic b_prev;
    int   exp_count;
    logic exp_valid;
    int   checks;
    int   errors;

    count_pulses #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_pulses (raw_pulses),
        .batch_done (batch_done),
        .reg_count  (reg_count),
`ifdef COUNT_PULSES_SAT_EN
        .reg_ovf    (reg_ovf),
`endif
        .reg_valid  (reg_valid)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic model_reset();
        credit_q.delete();
        r_prev    = 1'b0;
        b_prev    = 1'b0;
        exp_count = 0;
        exp_valid = 1'b0;
`ifdef COUNT_PULSES_SAT_EN
        exp_ovf   = 1'b0;
`endif
    endtask

    // Drive one clock of stimulus and advance the reference model.
    task automatic step(input logic r, input logic b);
        int tot;
        @(negedge clk);
        raw_pulses = r;
        batch_done = b;
        @(posedge clk);
        n_edge++;
        if (r && !r_prev) credit_q.push_back(n_edge + 2);
        exp_valid = 1'b0;
        if (b && !b_prev) begin
            tot = 0;
            while (credit_q.size() > 0 && credit_q[0] < n_edge) begin
                void'(credit_q.pop_front());
                tot++;
            end
`ifdef COUNT_PULSES_SAT_EN
            exp_count = (tot > MAXV) ? MAXV : tot;
            exp_ovf   = (tot > MAXV);
`else
            exp_count = tot % (MAXV + 1);
`endif
            exp_valid = 1'b1;
        end
        r_prev = r;
        b_prev = b;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        raw_pulses = 1'b0;
        batch_done = 1'b0;
        model_reset();
        #22;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (reg_count !== 8'd0 || reg_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state count=%0d valid=%b want 0/0",
                     reg_count, reg_valid);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
        idle(4);
        step(1'b0, 1'b1);
        checks++;
        if (reg_count !== 8'(exp_count) || exp_count != 3) begin
            errors++;
            $display("FAIL pre_reset count=%0d want %0d (model %0d)",
                     reg_count, 3, exp_count);
        end
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        @(negedge clk);
        clk_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (reg_count !== 8'd0 || reg_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset count=%0d valid=%b want 0/0",
                     reg_count, reg_valid);
        end
        model_reset();
        #10;
        rst_n = 1'b1;
        #3;
        clk_en = 1'b1;
        idle(3);
        step(1'b0, 1'b1);
        checks++;
        if (reg_count !== 8'd0 || reg_valid !== 1'b1) begin
            errors++;
            $display("FAIL empty_batch count=%0d valid=%b want 0/1",
                     reg_count, reg_valid);
        end
        step(1'b0, 1'b0);
        checks++;
        if (reg_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_strobe valid=%b want 0", reg_valid);
        end
    endtask

    task automatic test_periodic();
        int nb = 0;
        for (int i = 0; i < 300; i++) begin
            step(i % 5 == 0, i % 50 == 49);
            checks++;
            if (reg_count !== 8'(exp_count) || reg_valid !== exp_valid) begin
                errors++;
                $display("FAIL periodic i=%0d count=%0d valid=%b want %0d/%b",
                         i, reg_count, reg_valid, exp_count, exp_valid);
            end
            if (exp_valid) begin
                nb++;
                if (nb > 1) begin
                    checks++;
                    if (reg_count !== 8'd10) begin
                        errors++;
                        $display("FAIL periodic_ten count=%0d want 10",
                                 reg_count);
                    end
                end
            end
        end
    endtask

    task automatic test_coincidence();
        step(1'b0, 1'b1);
        idle(4);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        checks++;
        if (reg_count !== 8'd0 || reg_valid !== 1'b1) begin
            errors++;
            $display("FAIL coincide_excl count=%0d valid=%b want 0/1",
                     reg_count, reg_valid);
        end
        idle(5);
        step(1'b0, 1'b1);
        checks++;
        if (reg_count !== 8'd1 || reg_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL coincide_next count=%0d want 1", reg_count);
        end
    endtask

    task automatic test_level();
        int nv = 0;
        step(1'b0, 1'b1);
        idle(4);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
        idle(5);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        idle(5);
        for (int i = 0; i < 13; i++) begin
            step(1'b0, i < 10);
            if (reg_valid === 1'b1) nv++;
        end
        checks++;
        if (reg_count !== 8'd2 || reg_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL level_count count=%0d want 2", reg_count);
        end
        checks++;
        if (nv != 1) begin
            errors++;
            $display("FAIL level_strobes got %0d want 1", nv);
        end
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b1);
        idle(4);
        for (int i = 0; i < 257; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
        idle(3);
        step(1'b0, 1'b1);
`ifdef COUNT_PULSES_SAT_EN
        checks++;
        if (reg_count !== 8'd255 || reg_ovf !== 1'b1) begin
            errors++;
            $display("FAIL sat count=%0d ovf=%b want 255/1",
                     reg_count, reg_ovf);
        end
`else
        checks++;
        if (reg_count !== 8'd1 || reg_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL wrap count=%0d want 1", reg_count);
        end
`endif
        step(1'b0, 1'b0);
    endtask

    task automatic test_latency();
        step(1'b0, 1'b1);
        idle(4);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        checks++;
        if (reg_count !== 8'd0) begin
            errors++;
            $display("FAIL latency_k1 count=%0d want 0", reg_count);
        end
        idle(4);
        step(1'b0, 1'b1);
        checks++;
        if (reg_count !== 8'd1) begin
            errors++;
            $display("FAIL latency_carry count=%0d want 1", reg_count);
        end
        idle(3);
        step(1'b1, 1'b0);
        idle(2);
        step(1'b0, 1'b1);
        checks++;
        if (reg_count !== 8'd1 || reg_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL latency_k3 count=%0d want 1", reg_count);
        end
    endtask

    task automatic test_random();
        logic r;
        logic b;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 2) == 0);
            b = ($urandom_range(0, 15) == 0);
            step(r, b);
            checks++;
            if (reg_count !== 8'(exp_count) || reg_valid !== exp_valid) begin
                errors++;
                $display("FAIL random i=%0d count=%0d valid=%b want %0d/%b",
                         i, reg_count, reg_valid, exp_count, exp_valid);
            end
`ifdef COUNT_PULSES_SAT_EN
            checks++;
            if (reg_ovf !== exp_ovf) begin
                errors++;
                $display("FAIL random_ovf i=%0d ovf=%b want %b",
                         i, reg_ovf, exp_ovf);
            end
`endif
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        n_edge = 0;
        test_reset();
        test_periodic();
        test_coincidence();
        test_level();
        test_wrap();
        test_latency();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
